// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the packet arbiter in front of the shared adder.
// Holds the arbiter state encoding and the requester-id width helper.
package adder_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int DEFAULT_N = 12;

   function automatic int id_width(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational adder shared by all requesters; carry-out is dropped.
module adder #(
   parameter int N = 12
) (
   input  logic [N-1:0] input1,
   input  logic [N-1:0] input2,
   output logic [N-1:0] sum
);

   assign sum = input1 + input2;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after i_ptr,
// wrapping around the requester range.
module rr_pick #(
   parameter int R   = 4,
   parameter int IDW = 2
) (
   input  logic [R-1:0]   i_req,
   input  logic [IDW-1:0] i_ptr,
   output logic [IDW-1:0] o_grant,
   output logic           o_any
);

   logic [IDW:0] w_cand;

   // scan forward from the pointer; the first hit wins and later hits are ignored
   always_comb begin
      o_any   = 1'b0;
      o_grant = '0;
      w_cand  = '0;
      for (int k = 0; k < R; k++) begin
         w_cand  = {1'b0, i_ptr} + (IDW + 1)'(k);
         w_cand  = (w_cand >= (IDW + 1)'(R)) ? (w_cand - (IDW + 1)'(R)) : w_cand;
         o_grant = (!o_any && i_req[w_cand[IDW-1:0]]) ? w_cand[IDW-1:0] : o_grant;
         o_any   = o_any | i_req[w_cand[IDW-1:0]];
      end
   end

endmodule

// File: rtl/adder_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one adder between R requesters,
// with a programmable idle gap after each packet and flit/packet statistics.
module adder_packet_arbiter
   import adder_ctrl_pkg::*;
#(
   parameter int N     = DEFAULT_N,
   parameter int R     = 4,
   parameter int GAP_W = 8,
   parameter int CNT_W = 32,
   localparam int IDW  = id_width(R)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [R-1:0]     req_valid,
   input  logic [R-1:0]     req_last,
   input  logic [R*N-1:0]   req_op1,
   input  logic [R*N-1:0]   req_op2,
   output logic [R-1:0]     req_ready,
   input  logic [GAP_W-1:0] gap_cycles,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [N-1:0]     res_sum,
   output logic [IDW-1:0]   res_id,
   output logic             res_last,
   output logic             busy,
   output logic [CNT_W-1:0] flit_count,
   output logic [CNT_W-1:0] pkt_count
);

   state_t           r_state;
   state_t           w_next_state;
   logic [IDW-1:0]   r_rr_ptr;
   logic [IDW-1:0]   r_grant;
   logic [IDW-1:0]   w_pick;
   logic             w_any;
   logic             w_slot_free;
   logic             w_accept;
   logic             w_last_beat;
   logic [N-1:0]     r_op1;
   logic [N-1:0]     r_op2;
   logic [N-1:0]     w_sel_op1;
   logic [N-1:0]     w_sel_op2;
   logic [N-1:0]     w_sum;
   logic             r_res_valid;
   logic             r_res_last;
   logic [IDW-1:0]   r_res_id;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [CNT_W-1:0] r_flit_count;
   logic [CNT_W-1:0] r_pkt_count;

   rr_pick #(.R(R), .IDW(IDW)) u_rr_pick (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick),
      .o_any   (w_any)
   );

   // operands stay in registers between beats so idle cycles cause no adder toggling
   adder #(.N(N)) u_adder (
      .input1 (r_op1),
      .input2 (r_op2),
      .sum    (w_sum)
   );

   assign w_slot_free = !r_res_valid || res_ready;
   assign w_accept    = (r_state == ST_XFER) && w_slot_free && req_valid[r_grant];
   assign w_last_beat = w_accept && req_last[r_grant];

   // operand mux for the granted requester
   always_comb begin
      w_sel_op1 = '0;
      w_sel_op2 = '0;
      for (int i = 0; i < R; i++) begin
         w_sel_op1 = (r_grant == IDW'(i)) ? req_op1[i*N +: N] : w_sel_op1;
         w_sel_op2 = (r_grant == IDW'(i)) ? req_op2[i*N +: N] : w_sel_op2;
      end
   end

   // only the granted requester may see ready, and only while the result slot can take a beat
   always_comb begin
      req_ready          = '0;
      req_ready[r_grant] = (r_state == ST_XFER) && w_slot_free;
   end

   // next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: w_next_state = w_any ? ST_XFER : ST_IDLE;
         ST_XFER: begin
            if (w_last_beat) begin
               w_next_state = (gap_cycles != '0) ? ST_GAP : ST_IDLE;
            end else begin
               w_next_state = ST_XFER;
            end
         end
         ST_GAP:  w_next_state = (r_gap_cnt == GAP_W'(1)) ? ST_IDLE : ST_GAP;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // state, grant, operand, result and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= '0;
         r_grant      <= '0;
         r_op1        <= '0;
         r_op2        <= '0;
         r_res_valid  <= 1'b0;
         r_res_last   <= 1'b0;
         r_res_id     <= '0;
         r_gap_cnt    <= '0;
         r_flit_count <= '0;
         r_pkt_count  <= '0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == ST_IDLE) && w_any) begin
            r_grant <= w_pick;
         end
         if (w_accept) begin
            r_op1        <= w_sel_op1;
            r_op2        <= w_sel_op2;
            r_res_valid  <= 1'b1;
            r_res_id     <= r_grant;
            r_res_last   <= req_last[r_grant];
            r_flit_count <= r_flit_count + CNT_W'(1);
         end else if (res_ready) begin
            r_res_valid <= 1'b0;
         end
         // gap_cycles is captured only here, so later edits cannot stretch a running gap
         if (w_last_beat) begin
            r_pkt_count <= r_pkt_count + CNT_W'(1);
            r_rr_ptr    <= (r_grant == IDW'(R - 1)) ? '0 : (r_grant + IDW'(1));
            r_gap_cnt   <= gap_cycles;
         end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
         end
      end
   end

   assign res_valid  = r_res_valid;
   assign res_sum    = w_sum;
   assign res_id     = r_res_id;
   assign res_last   = r_res_last;
   assign busy       = (r_state != ST_IDLE);
   assign flit_count = r_flit_count;
   assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_adder_packet_arbiter.sv
// Directed bench for adder_packet_arbiter: per-requester flit queues feed the DUT,
// accepted flits push hand-computed results to a scoreboard drained by a monitor.
module tb_adder_packet_arbiter;

   localparam int N     = 12;
   localparam int R     = 4;
   localparam int GAP_W = 8;
   localparam int CNT_W = 32;

   typedef struct packed {
      logic          bub;
      logic          last;
      logic [N-1:0]  a;
      logic [N-1:0]  b;
      logic [N-1:0]  e;
   } flit_t;

   typedef struct packed {
      logic [1:0]    id;
      logic          last;
      logic [N-1:0]  sum;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [R-1:0]     req_valid;
   logic [R-1:0]     req_last;
   logic [R*N-1:0]   req_op1;
   logic [R*N-1:0]   req_op2;
   logic [R-1:0]     req_ready;
   logic [GAP_W-1:0] gap_cycles;
   logic             res_valid;
   logic             res_ready;
   logic [N-1:0]     res_sum;
   logic [1:0]       res_id;
   logic             res_last;
   logic             busy;
   logic [CNT_W-1:0] flit_count;
   logic [CNT_W-1:0] pkt_count;

   flit_t q [R][$];
   exp_t  sb[$];
   int    acc_log[$];
   int    acc_total;
   int    lasts_seen;
   logic [R-1:0] acc;
   flit_t f_hd;
   exp_t  e_fd;
   exp_t  e_mon;
   int    n_tests;
   int    n_fail;

   adder_packet_arbiter #(.N(N), .R(R), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .req_ready  (req_ready),
      .gap_cycles (gap_cycles),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_id     (res_id),
      .res_last   (res_last),
      .busy       (busy),
      .flit_count (flit_count),
      .pkt_count  (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] e, input logic last);
      flit_t f;
      f.bub = 1'b0; f.last = last; f.a = a; f.b = b; f.e = e;
      q[id].push_back(f);
   endtask

   task automatic bubble(input int id, input int n);
      flit_t f;
      f = '0;
      f.bub = 1'b1;
      for (int k = 0; k < n; k++) q[id].push_back(f);
   endtask

   function automatic logic [31:0] log_word();
      logic [31:0] v;
      v = 32'd0;
      foreach (acc_log[k]) v = (v << 4) | 32'(acc_log[k]);
      return v;
   endfunction

   task automatic drain(input string name);
      bit done;
      bit qe;
      done = 1'b0;
      for (int k = 0; k < 600 && !done; k++) begin
         @(negedge clk);
         qe = 1'b1;
         for (int i = 0; i < R; i++) if (q[i].size() != 0) qe = 1'b0;
         if (qe && sb.size() == 0 && !busy && !res_valid) done = 1'b1;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_%s: traffic still pending (sb=%0d busy=%b)", name, sb.size(), busy);
      end
   endtask

   task automatic wait_acc(input string name, input int target);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 600 && !done; k++) begin
         @(posedge clk); #2;
         if (acc_total >= target) done = 1'b1;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_%s: accepted %0d, required %0d", name, acc_total, target);
      end
   endtask

   // feeder: decides acceptance just before the edge, then pops and presents after it
   initial begin : feeder
      forever begin
         @(negedge clk);
         for (int i = 0; i < R; i++) acc[i] = req_valid[i] && req_ready[i] && !rst;
         @(posedge clk); #1;
         for (int i = 0; i < R; i++) begin
            if (acc[i] && q[i].size() > 0) begin
               f_hd = q[i].pop_front();
               e_fd.id = 2'(i); e_fd.last = f_hd.last; e_fd.sum = f_hd.e;
               sb.push_back(e_fd);
               acc_log.push_back(i);
               acc_total++;
               if (f_hd.last) lasts_seen++;
            end
            if (q[i].size() > 0 && q[i][0].bub) begin
               void'(q[i].pop_front());
               req_valid[i] = 1'b0;
            end else if (q[i].size() > 0) begin
               req_valid[i]       = 1'b1;
               req_last[i]        = q[i][0].last;
               req_op1[i*N +: N]  = q[i][0].a;
               req_op2[i*N +: N]  = q[i][0].b;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // monitor: compares every completed output handshake against the scoreboard
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("ready_onehot", {31'd0, ($countones(req_ready) <= 1)}, 32'd1);
            if (res_valid && res_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_result", {31'd0, res_valid}, 32'd0);
               end else begin
                  e_mon = sb.pop_front();
                  chk("res_sum",  32'(res_sum),  32'(e_mon.sum));
                  chk("res_id",   32'(res_id),   32'(e_mon.id));
                  chk("res_last", 32'(res_last), 32'(e_mon.last));
               end
            end
         end
      end
   end

   initial begin : main
      int base;
      logic [N-1:0] a;
      logic [N-1:0] b;
      n_tests = 0; n_fail = 0; acc_total = 0; lasts_seen = 0;
      rst = 1'b1; req_valid = '0; req_last = '0; req_op1 = '0; req_op2 = '0;
      res_ready = 1'b1; gap_cycles = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_res_sum", 32'(res_sum), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_res_last", {31'd0, res_last}, 32'd0);
      chk("rst_flit_count", flit_count, 32'd0);
      chk("rst_pkt_count", pkt_count, 32'd0);
      @(posedge clk); #2 rst = 1'b0;

      // three flits from requester 1, including carry wrap
      send(1, 12'h001, 12'h002, 12'h003, 1'b0);
      send(1, 12'h7FF, 12'h001, 12'h800, 1'b0);
      send(1, 12'hFFF, 12'h001, 12'h000, 1'b1);
      drain("t1");
      chk("t1_flit_count", flit_count, 32'd3);
      chk("t1_pkt_count", pkt_count, 32'd1);

      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      acc_log.delete();

      // three competing requesters from rr_ptr 0
      send(0, 12'h010, 12'h020, 12'h030, 1'b0);
      send(0, 12'h111, 12'h222, 12'h333, 1'b1);
      send(2, 12'h0F0, 12'h00F, 12'h0FF, 1'b0);
      send(2, 12'hABC, 12'h544, 12'h000, 1'b1);
      send(3, 12'h400, 12'h400, 12'h800, 1'b0);
      send(3, 12'h9FE, 12'h001, 12'h9FF, 1'b1);
      drain("t2");
      chk("t2_order", log_word(), 32'h0000_2233);
      chk("t2_flit_count", flit_count, 32'd6);
      chk("t2_pkt_count", pkt_count, 32'd3);

      // pointer back at 0: requester 1 beats requester 3
      acc_log.delete();
      send(3, 12'h001, 12'h001, 12'h002, 1'b1);
      send(1, 12'h003, 12'h004, 12'h007, 1'b1);
      drain("t2b");
      chk("t2b_order", log_word(), 32'h0000_0013);

      // alternating extremes, then requester valid drops for 4 cycles mid-packet
      base = acc_total;
      send(0, 12'h000, 12'h000, 12'h000, 1'b0);
      send(0, 12'hFFF, 12'hFFF, 12'hFFE, 1'b0);
      send(0, 12'h000, 12'h000, 12'h000, 1'b0);
      send(0, 12'hFFF, 12'h000, 12'hFFF, 1'b0);
      bubble(0, 4);
      send(0, 12'h001, 12'hFFF, 12'h000, 1'b1);
      wait_acc("t3", base + 4);
      @(negedge clk);
      chk("t3_sum_hold0", 32'(res_sum), 32'h0000_0FFF);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk("t3_sum_hold", 32'(res_sum), 32'h0000_0FFF);
         chk("t3_no_valid", {31'd0, res_valid}, 32'd0);
      end
      drain("t3");
      chk("t3_flit_count", flit_count, 32'd13);

      // consumer stalls for 5 cycles mid-packet
      base = acc_total;
      send(3, 12'h100, 12'h023, 12'h123, 1'b0);
      send(3, 12'h0AB, 12'h0CD, 12'h178, 1'b0);
      send(3, 12'h800, 12'h800, 12'h000, 1'b0);
      send(3, 12'h555, 12'h2AA, 12'h7FF, 1'b0);
      send(3, 12'h123, 12'h321, 12'h444, 1'b0);
      send(3, 12'hF00, 12'h0FF, 12'hFFF, 1'b1);
      wait_acc("t4", base + 2);
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t4_ready_low", 32'(req_ready), 32'd0);
         chk("t4_valid_held", {31'd0, res_valid}, 32'd1);
         chk("t4_sum_stable", 32'(res_sum), 32'h0000_0178);
         chk("t4_id_stable", 32'(res_id), 32'd3);
      end
      @(posedge clk); #2 res_ready = 1'b1;
      drain("t4");
      chk("t4_flit_count", flit_count, 32'd19);
      chk("t4_pkt_count", pkt_count, 32'd7);

      // 7-cycle gap between two back-to-back 20-flit packets from a lone requester
      gap_cycles = 8'd7;
      base = lasts_seen;
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < 20; j++) begin
            a = 12'(j * 37 + p);
            b = 12'(j * 101 + 5);
            send(2, a, b, a + b, (j == 19));
         end
      end
      for (int k = 0; k < 600 && lasts_seen == base; k++) begin
         @(posedge clk); #2;
      end
      chk("t5_first_last_seen", 32'(lasts_seen), 32'(base + 1));
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk("t5_gap_busy", {31'd0, busy}, 32'd1);
         chk("t5_gap_ready", 32'(req_ready), 32'd0);
         if (k == 0) gap_cycles = 8'd3;
      end
      @(negedge clk);
      chk("t5_idle_busy", {31'd0, busy}, 32'd0);
      chk("t5_idle_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("t5_xfer_ready", 32'(req_ready), 32'b0100);
      drain("t5");
      gap_cycles = 8'd0;
      chk("t5_flit_count", flit_count, 32'd59);
      chk("t5_pkt_count", pkt_count, 32'd9);

      // reset during flit 2 of 5; pointer was left at 3
      base = acc_total;
      for (int j = 0; j < 5; j++) send(1, 12'(j + 1), 12'h001, 12'(j + 2), (j == 4));
      wait_acc("t6", base + 1);
      rst = 1'b1;
      q[1].delete();
      @(posedge clk);
      @(negedge clk);
      chk("t6_res_valid", {31'd0, res_valid}, 32'd0);
      chk("t6_req_ready", 32'(req_ready), 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_flit_count", flit_count, 32'd0);
      chk("t6_pkt_count", pkt_count, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      sb.delete();
      acc_log.delete();
      send(3, 12'h0B0, 12'h050, 12'h100, 1'b1);
      send(2, 12'h00A, 12'h005, 12'h00F, 1'b1);
      drain("t6");
      chk("t6_order", log_word(), 32'h0000_0023);
      chk("t6_flit_after", flit_count, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
